// File: rtl/gcm_ae_hw_1x8_hls_deadlock_report_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | gcm_ae_hw_1x8_hls_deadlock_report_pkg                              |
// | Shared types/constants for the deadlock report block. Rev 1.0      |
// +--------------------------------------------------------------------+
package gcm_ae_hw_1x8_hls_deadlock_report_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SUSPECT   = 2'd1,
    ST_CONFIRMED = 2'd2
  } state_t;

  localparam int DEFAULT_THRESHOLD = 16;
  localparam int DEFAULT_NUM_AXIS  = 7;

  function automatic int cnt_width(input int thr);
    return $clog2(thr + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/gcm_ae_hw_1x8_hls_deadlock_persist_cnt.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | gcm_ae_hw_1x8_hls_deadlock_persist_cnt                             |
// | Saturating persistence counter with terminal-count flag. Rev 1.0   |
// +--------------------------------------------------------------------+
module gcm_ae_hw_1x8_hls_deadlock_persist_cnt #(
  parameter int THRESHOLD = 16,
  parameter int CW        = 5
) (
  input  logic clock,
  input  logic reset,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_tc
);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clock) begin
    if (reset || i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != CW'(THRESHOLD))) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // High when the next increment is the THRESHOLD-th consecutive sample.
  assign o_tc = (r_cnt == CW'(THRESHOLD - 1));

endmodule
`default_nettype wire

// File: rtl/gcm_ae_hw_1x8_hls_deadlock_report.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | gcm_ae_hw_1x8_hls_deadlock_report                                  |
// | Confirms persistent monitor blocking and latches a deadlock report.|
// | Optional timestamp: GCM_DEADLOCK_REPORT_TIMESTAMP_EN. Rev 1.0      |
// +--------------------------------------------------------------------+
module gcm_ae_hw_1x8_hls_deadlock_report
  import gcm_ae_hw_1x8_hls_deadlock_report_pkg::*;
#(
  parameter int THRESHOLD = DEFAULT_THRESHOLD,
  parameter int NUM_AXIS  = DEFAULT_NUM_AXIS
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                block,
  input  logic [NUM_AXIS-1:0] axis_block_sigs,
  input  logic                clear_i,
  output logic                deadlock_o,
  output logic                report_valid_o,
  output logic [NUM_AXIS-1:0] deadlock_axis_o,
  output logic [7:0]          deadlock_cnt_o
`ifdef GCM_DEADLOCK_REPORT_TIMESTAMP_EN
  ,
  output logic [31:0]         timestamp_o
`endif
);

  localparam int CW = cnt_width(THRESHOLD);

  state_t              r_state;
  state_t              w_next_state;
  logic                w_active;
  logic                w_inc;
  logic                w_clr;
  logic                w_tc;
  logic                w_confirm;
  logic                r_deadlock;
  logic                r_report_valid;
  logic [NUM_AXIS-1:0] r_axis;
  logic [7:0]          r_cnt;

  assign w_active  = (r_state != ST_CONFIRMED);
  assign w_inc     = w_active && block && !clear_i;
  assign w_clr     = clear_i || (w_active && !block);
  // A clear on the confirming sample wins: no report is raised.
  assign w_confirm = w_active && block && !clear_i && w_tc;

  gcm_ae_hw_1x8_hls_deadlock_persist_cnt #(
    .THRESHOLD (THRESHOLD),
    .CW        (CW)
  ) u_persist_cnt (
    .clock (clock),
    .reset (reset),
    .i_inc (w_inc),
    .i_clr (w_clr),
    .o_tc  (w_tc)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      ST_IDLE, ST_SUSPECT: begin
        if (clear_i || !block) begin
          w_next_state = ST_IDLE;
        end else if (w_tc) begin
          w_next_state = ST_CONFIRMED;
        end else begin
          w_next_state = ST_SUSPECT;
        end
      end
      ST_CONFIRMED: begin
        if (clear_i) begin
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_deadlock     <= 1'b0;
      r_report_valid <= 1'b0;
      r_axis         <= '0;
      r_cnt          <= '0;
    end else begin
      r_report_valid <= w_confirm;
      if (w_confirm) begin
        r_deadlock <= 1'b1;
        r_axis     <= axis_block_sigs;
        if (r_cnt != 8'hFF) begin
          r_cnt <= r_cnt + 8'd1;
        end
      end else if (clear_i) begin
        r_deadlock <= 1'b0;
        r_axis     <= '0;
      end
    end
  end

  assign deadlock_o      = r_deadlock;
  assign report_valid_o  = r_report_valid;
  assign deadlock_axis_o = r_axis;
  assign deadlock_cnt_o  = r_cnt;

`ifdef GCM_DEADLOCK_REPORT_TIMESTAMP_EN
  logic [31:0] r_cycle;
  logic [31:0] r_timestamp;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_cycle     <= '0;
      r_timestamp <= '0;
    end else begin
      r_cycle <= r_cycle + 32'd1;
      if (w_confirm) begin
        r_timestamp <= r_cycle;
      end else if (clear_i) begin
        r_timestamp <= '0;
      end
    end
  end

  assign timestamp_o = r_timestamp;
`endif

endmodule
`default_nettype wire
